// File: rtl/icache_pkg.sv
// Shared types and derived geometry for the parametrised instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FETCH = 2'd2,
        FILL  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_SETS   = 16;
    localparam int DEF_WAYS   = 4;

    localparam int INDEX_W = $clog2(DEF_SETS);
    localparam int TAG_W   = DEF_ADDR_W - INDEX_W;
    localparam int AGE_W   = $clog2(DEF_WAYS);

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int age_w(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/icache_lru_set.sv
// True-LRU age counters for one cache set plus victim selection.
module icache_lru_set
    import icache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int AGE_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd,
    input  logic [AGE_W-1:0] i_way,
    input  logic [WAYS-1:0]  i_valid,
    output logic [AGE_W-1:0] o_victim
);

    logic [AGE_W-1:0] r_age [WAYS];
    logic [AGE_W-1:0] w_lru;
    logic [AGE_W-1:0] w_inv;
    logic             w_any_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) r_age[w] <= AGE_W'(w);
        end else if (i_upd) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == i_way)
                    r_age[w] <= '0;
                else if (r_age[w] < r_age[i_way])
                    r_age[w] <= r_age[w] + 1'b1;
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_lru     = '0;
        w_inv     = '0;
        w_any_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_age[w] == AGE_W'(WAYS - 1)) w_lru = AGE_W'(w);
            if (!i_valid[w]) begin
                w_inv     = AGE_W'(w);
                w_any_inv = 1'b1;
            end
        end
        o_victim = w_any_inv ? w_inv : w_lru;
    end

endmodule

// File: rtl/icache_param.sv
// Set-associative read-only instruction cache with true-LRU replacement and
// a request/grant common-bus miss handler.
module icache_param
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PrRd,
    input  logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] Data_Bus,
    output logic              CPU_stall,
    output logic              Com_Bus_Req_proc,
    input  logic              Com_Bus_Gnt_proc,
    output logic [ADDR_W-1:0] Address_Com,
    input  logic [ADDR_W-1:0] Data_Bus_Com,
    input  logic              Data_in_Bus,
    input  logic              Flush
);

    localparam int IDX_W = index_w(SETS);
    localparam int T_W   = ADDR_W - IDX_W;
    localparam int A_W   = age_w(WAYS);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fill_data;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [T_W-1:0]    r_tag   [SETS][WAYS];
    logic [ADDR_W-1:0] r_data  [SETS][WAYS];

    logic [IDX_W-1:0]  w_idx;
    logic [T_W-1:0]    w_tag;
    logic [IDX_W-1:0]  w_fidx;
    logic [T_W-1:0]    w_ftag;
    logic              w_hit;
    logic [A_W-1:0]    w_hit_way;
    logic [ADDR_W-1:0] w_hit_data;
    logic              w_hit_acc;
    logic              w_fill;
    logic              w_miss_start;
    logic [A_W-1:0]    w_victim [SETS];
    logic [A_W-1:0]    w_fvictim;
    logic [A_W-1:0]    w_upd_way;
    logic [SETS-1:0]   w_upd;

    assign w_idx  = Address[IDX_W-1:0];
    assign w_tag  = Address[ADDR_W-1:IDX_W];
    assign w_fidx = r_addr[IDX_W-1:0];
    assign w_ftag = r_addr[ADDR_W-1:IDX_W];

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_way  = A_W'(w);
                w_hit_data = r_data[w_idx][w];
            end
        end
    end

    assign w_hit_acc    = (r_state == IDLE) && PrRd && w_hit;
    assign w_miss_start = (r_state == IDLE) && PrRd && !w_hit;
    assign w_fill       = (r_state == FILL);
    assign w_fvictim    = w_victim[w_fidx];
    assign w_upd_way    = w_fill ? w_fvictim : w_hit_way;

    for (genvar s = 0; s < SETS; s++) begin : g_set
        assign w_upd[s] = (w_hit_acc && (w_idx == IDX_W'(s))) ||
                          (w_fill && (w_fidx == IDX_W'(s)));

        icache_lru_set #(
            .WAYS  (WAYS),
            .AGE_W (A_W)
        ) u_lru (
            .clk      (clk),
            .rst      (rst),
            .i_upd    (w_upd[s]),
            .i_way    (w_upd_way),
            .i_valid  (r_valid[s]),
            .o_victim (w_victim[s])
        );
    end

    // The fill write comes after the flush clear so an in-flight line survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_miss_start)     r_state <= REQ;
                REQ:     if (Com_Bus_Gnt_proc) r_state <= FETCH;
                FETCH:   if (Data_in_Bus)      r_state <= FILL;
                FILL:                          r_state <= IDLE;
                default:                       r_state <= IDLE;
            endcase
            if (Flush) begin
                for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
            end
            if (w_fill) r_valid[w_fidx][w_fvictim] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss_start) r_addr <= Address;
        if ((r_state == FETCH) && Data_in_Bus) r_fill_data <= Data_Bus_Com;
        if (w_fill) begin
            r_tag[w_fidx][w_fvictim]  <= w_ftag;
            r_data[w_fidx][w_fvictim] <= r_fill_data;
        end
    end

    // State is forced to IDLE asynchronously; stall is gated so it drops with rst too.
    assign Data_Bus         = w_fill ? r_fill_data : (w_hit_acc ? w_hit_data : '0);
    assign CPU_stall        = !rst && PrRd && (r_state != FILL) &&
                              ((r_state != IDLE) || !w_hit);
    assign Com_Bus_Req_proc = (r_state == REQ) || (r_state == FETCH);
    assign Address_Com      = ((r_state == FETCH) && Com_Bus_Gnt_proc) ? r_addr : '0;

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: cold miss, hits, LRU eviction, flush, reset mid-miss.
module tb_icache_param;

    logic        clk;
    logic        rst;
    logic        PrRd;
    logic [31:0] Address;
    logic [31:0] Data_Bus;
    logic        CPU_stall;
    logic        Com_Bus_Req_proc;
    logic        Com_Bus_Gnt_proc;
    logic [31:0] Address_Com;
    logic [31:0] Data_Bus_Com;
    logic        Data_in_Bus;
    logic        Flush;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [12];
    vec_t one;

    icache_param #(.ADDR_W(32), .SETS(16), .WAYS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .PrRd             (PrRd),
        .Address          (Address),
        .Data_Bus         (Data_Bus),
        .CPU_stall        (CPU_stall),
        .Com_Bus_Req_proc (Com_Bus_Req_proc),
        .Com_Bus_Gnt_proc (Com_Bus_Gnt_proc),
        .Address_Com      (Address_Com),
        .Data_Bus_Com     (Data_Bus_Com),
        .Data_in_Bus      (Data_in_Bus),
        .Flush            (Flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] fd(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single IDLE-state lookup; a hit is held across the edge so LRU updates,
    // a miss drops PrRd before the edge so no fill starts.
    task automatic probe(input vec_t v);
        @(negedge clk);
        PrRd = 1'b1; Address = v.addr; Flush = 1'b0;
        #2;
        chk($sformatf("probe %h stall", v.addr), {31'b0, CPU_stall}, {31'b0, !v.hit});
        chk($sformatf("probe %h req", v.addr), {31'b0, Com_Bus_Req_proc}, 32'd0);
        if (v.hit) chk($sformatf("probe %h data", v.addr), Data_Bus, v.data);
        else PrRd = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] d,
                           input int gw, input int dr, input bit fl);
        @(negedge clk);
        PrRd = 1'b1; Address = a; Flush = 1'b0; Com_Bus_Gnt_proc = 1'b0; Data_in_Bus = 1'b0;
        #2;
        chk($sformatf("miss %h idle stall", a), {31'b0, CPU_stall}, 32'd1);
        chk($sformatf("miss %h idle req", a), {31'b0, Com_Bus_Req_proc}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < gw; i++) begin
            Data_in_Bus = 1'b1; Data_Bus_Com = 32'hBAD0_0000 | i;
            #2;
            chk($sformatf("miss %h req wait req", a), {31'b0, Com_Bus_Req_proc}, 32'd1);
            chk($sformatf("miss %h req wait acom", a), Address_Com, 32'd0);
            chk($sformatf("miss %h req wait stall", a), {31'b0, CPU_stall}, 32'd1);
            @(negedge clk);
        end
        Data_in_Bus = 1'b0; Com_Bus_Gnt_proc = 1'b1;
        #2;
        chk($sformatf("miss %h req req", a), {31'b0, Com_Bus_Req_proc}, 32'd1);
        chk($sformatf("miss %h req acom", a), Address_Com, 32'd0);
        @(negedge clk);
        Flush = fl;
        for (int i = 0; i < dr; i++) begin
            Com_Bus_Gnt_proc = 1'b0;
            #2;
            chk($sformatf("miss %h gnt drop acom", a), Address_Com, 32'd0);
            chk($sformatf("miss %h gnt drop req", a), {31'b0, Com_Bus_Req_proc}, 32'd1);
            @(negedge clk);
            Flush = 1'b0;
        end
        Com_Bus_Gnt_proc = 1'b1;
        #2;
        chk($sformatf("miss %h fetch acom", a), Address_Com, a);
        chk($sformatf("miss %h fetch req", a), {31'b0, Com_Bus_Req_proc}, 32'd1);
        chk($sformatf("miss %h fetch stall", a), {31'b0, CPU_stall}, 32'd1);
        Data_in_Bus = 1'b1; Data_Bus_Com = d;
        @(negedge clk);
        Flush = 1'b0; Data_in_Bus = 1'b0; Com_Bus_Gnt_proc = 1'b0;
        #2;
        chk($sformatf("miss %h fill data", a), Data_Bus, d);
        chk($sformatf("miss %h fill stall", a), {31'b0, CPU_stall}, 32'd0);
        chk($sformatf("miss %h fill req", a), {31'b0, Com_Bus_Req_proc}, 32'd0);
        chk($sformatf("miss %h fill acom", a), Address_Com, 32'd0);
        PrRd = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h200, 1'b1, fd(32'h200)};
        tbl[1]  = '{32'h300, 1'b1, fd(32'h300)};
        tbl[2]  = '{32'h400, 1'b1, fd(32'h400)};
        tbl[3]  = '{32'h500, 1'b1, fd(32'h500)};
        tbl[4]  = '{32'h100, 1'b0, 32'h0};
        tbl[5]  = '{32'h201, 1'b0, 32'h0};
        tbl[6]  = '{32'h101, 1'b1, fd(32'h101)};
        tbl[7]  = '{32'h301, 1'b1, fd(32'h301)};
        tbl[8]  = '{32'h401, 1'b1, fd(32'h401)};
        tbl[9]  = '{32'h501, 1'b1, fd(32'h501)};
        tbl[10] = '{32'h600, 1'b1, fd(32'h600)};
        tbl[11] = '{32'h300, 1'b0, 32'h0};

        rst = 1'b1; PrRd = 1'b0; Address = '0; Com_Bus_Gnt_proc = 1'b0;
        Data_Bus_Com = '0; Data_in_Bus = 1'b0; Flush = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset data", Data_Bus, 32'd0);
        chk("reset stall", {31'b0, CPU_stall}, 32'd0);
        chk("reset req", {31'b0, Com_Bus_Req_proc}, 32'd0);
        chk("reset acom", Address_Com, 32'd0);
        PrRd = 1'b1;
        #1;
        chk("reset stall with PrRd", {31'b0, CPU_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0; PrRd = 1'b0;

        // Cold read, then same-cycle hit.
        do_miss(32'h100, 32'hDEAD_BEEF, 0, 0, 1'b0);
        one = '{32'h100, 1'b1, 32'hDEAD_BEEF};
        probe(one);

        // Flush together with a hit: data now, line gone afterwards.
        @(negedge clk);
        PrRd = 1'b1; Address = 32'h100; Flush = 1'b1;
        #2;
        chk("flush+hit stall", {31'b0, CPU_stall}, 32'd0);
        chk("flush+hit data", Data_Bus, 32'hDEAD_BEEF);
        do_miss(32'h100, 32'hDEAD_BEEF, 2, 1, 1'b0);

        // Five conflicting tags in set 0.
        @(negedge clk);
        PrRd = 1'b0; Flush = 1'b1;
        for (int i = 1; i <= 5; i++) do_miss(32'h100 * i, fd(32'h100 * i), 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) probe(tbl[i]);

        // Set 1: touch the oldest way before the fifth fill.
        for (int i = 1; i <= 4; i++) do_miss(32'h100 * i + 1, fd(32'h100 * i + 1), 0, 0, 1'b0);
        one = '{32'h101, 1'b1, fd(32'h101)};
        probe(one);
        do_miss(32'h501, fd(32'h501), 0, 0, 1'b0);
        for (int i = 5; i < 10; i++) probe(tbl[i]);

        // Flush while fetching: the new line survives, older ones do not.
        do_miss(32'h600, fd(32'h600), 0, 1, 1'b1);
        for (int i = 10; i < 12; i++) probe(tbl[i]);

        // Reset in the middle of a fetch.
        @(negedge clk);
        PrRd = 1'b1; Address = 32'h700;
        #2;
        chk("rst seq idle stall", {31'b0, CPU_stall}, 32'd1);
        @(negedge clk);
        Com_Bus_Gnt_proc = 1'b1;
        @(negedge clk);
        #2;
        chk("rst seq fetch acom", Address_Com, 32'h700);
        Data_in_Bus = 1'b1; Data_Bus_Com = 32'h7777_7777;
        rst = 1'b1;
        #1;
        chk("rst mid-miss req", {31'b0, Com_Bus_Req_proc}, 32'd0);
        chk("rst mid-miss acom", Address_Com, 32'd0);
        chk("rst mid-miss stall", {31'b0, CPU_stall}, 32'd0);
        chk("rst mid-miss data", Data_Bus, 32'd0);
        @(negedge clk);
        rst = 1'b0; PrRd = 1'b0; Data_in_Bus = 1'b0; Com_Bus_Gnt_proc = 1'b0;
        one = '{32'h700, 1'b0, 32'h0};
        probe(one);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_param.md
# icache_param

Parametrised instruction cache for one core of the multi-core system: a read-only, set-associative cache with true-LRU replacement and a common-bus miss handler. It generalises the fixed-geometry per-core instruction cache. Sets, ways and widths are parameters. It adds a registered miss state machine with a request/grant handshake and a single-cycle flush. It sits between a core's fetch port and the shared common-bus arbiter.

## Interface
- ADDR_W, 32, address and data width in bits (one word per line)
- SETS, 16, number of sets (power of two, ≥2)
- WAYS, 4, associativity (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- PrRd  in  1  processor read request, held until CPU_stall low
- Address  in  ADDR_W  word address of fetch
- Data_Bus  out  ADDR_W  instruction returned to core
- CPU_stall  out  1  core must hold request
- Com_Bus_Req_proc  out  1  common-bus request
- Com_Bus_Gnt_proc  in  1  common-bus grant
- Address_Com  out  ADDR_W  miss address driven on the common bus, 0 when not granted
- Data_Bus_Com  in  ADDR_W  fill data from memory
- Data_in_Bus  in  1  Data_Bus_Com valid this cycle
- Flush  in  1  invalidate all lines

## Operation
- Address split: index = Address[log2(SETS)-1:0]; tag = remaining upper bits.
- Per line: valid bit, tag, data word. Per set: WAYS age counters, each log2(WAYS) bits. Age 0 is MRU, WAYS-1 is LRU.
- FSM states:
  - IDLE → REQ on PrRd && miss.
  - REQ → FETCH on Com_Bus_Gnt_proc.
  - FETCH → FILL on Data_in_Bus.
  - FILL → IDLE unconditionally.
- Hit in IDLE:
  - Data_Bus = hit way data.
  - CPU_stall = 0.
  - Ages of that set are updated at the clock edge.
- Miss:
  - The request address is latched at the IDLE→REQ edge.
  - Com_Bus_Req_proc = 1 in REQ and FETCH.
  - Address_Com = latched address in FETCH only.
- FILL:
  - Victim is the first invalid way (lowest index). Otherwise the way with age WAYS-1.
  - Victim is written valid with tag and captured data.
  - Data_Bus = captured data; CPU_stall = 0.
- LRU update on hit or fill: accessed way → age 0. Ways younger than its old age increment by 1; others unchanged.
- CPU_stall = 1 when PrRd && state ≠ FILL && (state ≠ IDLE || miss). Otherwise 0.
- Flush clears every valid bit at the next edge; ages are untouched.
  - Flush in REQ/FETCH/FILL: the in-flight fill still completes and its line stays valid.
  - Flush and a hit in the same IDLE cycle: the hit data is returned this cycle, then the line is invalid.
- Grant dropped while in FETCH: remain in FETCH; Address_Com = 0 until grant returns.

## Timing
- Reset values:
  - state IDLE
  - all valid bits 0
  - each set's ages = way index
  - all outputs 0 (Data_Bus, CPU_stall, Com_Bus_Req_proc, Address_Com)
- Hit latency 0: combinational data in the PrRd cycle.
- Miss latency = 1 (REQ entry) + grant wait + Data_in_Bus wait + 1 (FILL). Minimum 3 cycles, with grant and data each arriving in the first cycle of their state.
- Data_in_Bus while not in FETCH: ignored.
- rst mid-miss: the FSM returns to IDLE immediately, the request drops the same cycle, and the fill is discarded.

## Structure
- Shared package icache_pkg:
  - state enum (IDLE, REQ, FETCH, FILL)
  - derived widths INDEX_W = clog2(SETS), TAG_W = ADDR_W − INDEX_W, AGE_W = clog2(WAYS)
- One sub-module, icache_lru_set: the age-update and victim-select logic for one set, instantiated SETS times.

## Test plan
- Cold read: Address 0x100 after reset, grant at +1, Data_in_Bus at +2 with 0xDEADBEEF → Req high for 2 cycles, Address_Com = 0x100 in FETCH, FILL returns 0xDEADBEEF with CPU_stall 0.
- Re-read 0x100 → same-cycle Data_Bus 0xDEADBEEF, CPU_stall 0, Req never asserted.
- WAYS=4: fill 5 conflicting tags into set 0, then re-read the first tag → the first tag was evicted and misses; tags 2–5 all hit.
- Hit on the oldest way before the 5th fill → the second-filled tag is evicted instead.
- Flush after filling 0x100, then read 0x100 → miss with full handshake.
- Assert rst during FETCH → Req, Address_Com and CPU_stall are 0 at once; a subsequent read of the same address misses.
